// File: rtl/dmem_stall.sv
// dmem_stall: multi-cycle data memory for the MIPS core.
// An accepted access waits LATENCY cycles (busy=1), then completes with a
// one-cycle ready pulse carrying rd/err. Writes merge byte lanes under be.
// Addresses with a[31:2] >= DEPTH complete with err=1 and rd=0 and do not
// touch the array.
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   req, we         access request (held until ready), 1 = write
//   a, wd, be       byte address, lane-aligned write data, lane enables
//   rd, err         read data / out-of-range flag, valid with ready
//   ready, busy     completion pulse, stall indication
module dmem_stall #(
  parameter int unsigned DEPTH   = 64,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] a,
  input  logic [31:0] wd,
  input  logic [3:0]  be,
  output logic [31:0] rd,
  output logic        ready,
  output logic        busy,
  output logic        err
);

  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_we;
  logic [29:0]   r_widx;
  logic [31:0]   r_wd;
  logic [3:0]    r_be;
  logic [31:0]   r_rd;
  logic          r_ready;
  logic          r_busy;
  logic          r_err;

  // Array is deliberately left without reset; contents are undefined at power-up.
  logic [31:0]   r_mem [DEPTH];

  logic          w_in_range;
  logic          w_commit;
  logic [IW-1:0] w_mem_idx;
  logic          w_unused_ok;

  // Byte-offset bits of the address never select anything.
  assign w_unused_ok = ^a[1:0];

  assign w_in_range = ({2'b00, r_widx} < DEPTH);
  assign w_commit   = (r_state == S_WAIT) && (r_cnt == '0);
  assign w_mem_idx  = r_widx[IW-1:0];

  // Control FSM with registered outputs; the access happens on the WAIT->RESP edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_ready <= 1'b0;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
      r_rd    <= '0;
      r_we    <= 1'b0;
      r_widx  <= '0;
      r_wd    <= '0;
      r_be    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_ready <= 1'b0;
          r_busy  <= 1'b0;
          if (req) begin
            r_we    <= we;
            r_widx  <= a[31:2];
            r_wd    <= wd;
            r_be    <= be;
            r_cnt   <= CW'(LATENCY - 1);
            r_busy  <= 1'b1;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CW'(1);
          end else begin
            r_busy  <= 1'b0;
            r_ready <= 1'b1;
            r_state <= S_RESP;
            if (!w_in_range) begin
              r_rd  <= '0;
              r_err <= 1'b1;
            end else begin
              r_err <= 1'b0;
              if (!r_we) begin
                r_rd <= r_mem[w_mem_idx];
              end
            end
          end
        end
        S_RESP: begin
          // req seen here belongs to the completing access; only IDLE accepts.
          r_ready <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_ready <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Lane-masked array write; a reset on the commit edge drops the write.
  always_ff @(posedge clk) begin
    if (!reset && w_commit && r_we && w_in_range) begin
      for (int i = 0; i < 4; i++) begin
        if (r_be[i]) begin
          r_mem[w_mem_idx][8*i +: 8] <= r_wd[8*i +: 8];
        end
      end
    end
  end

  assign rd    = r_rd;
  assign ready = r_ready;
  assign busy  = r_busy;
  assign err   = r_err;

endmodule
